// File: rtl/axis_byte_packer.sv
// Packs a narrow AXI-Stream into OUT_WIDTH-bit words behind a single output register.
// A completing beat may load the register in the same cycle the previous word drains.
module axis_byte_packer #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 32,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 clr,
    input  logic [IN_WIDTH-1:0]  s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [OUT_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 partial
);

    localparam int unsigned N    = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    // With N == 1 the accumulator is never written; keep one beat wide to stay legal.
    localparam int unsigned AccW = (N > 1) ? (N - 1) * IN_WIDTH : IN_WIDTH;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [AccW-1:0]      acc_q, acc_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 partial_q, partial_d;

    logic                 accept;
    logic                 complete;
    logic [OUT_WIDTH-1:0] slots;
    logic [OUT_WIDTH-1:0] word;

    // Combinational on m_axis_tready so a completing beat can overlap the drain.
    assign s_axis_tready = arstn && !clr &&
                           ((cnt_q != LastCnt) || !out_valid_q || m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign complete      = accept && (cnt_q == LastCnt);

    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign partial       = partial_q;

    // slots holds beats in arrival order, beat k at [k*IN_WIDTH +: IN_WIDTH].
    always_comb begin
        slots = '0;
        for (int unsigned k = 0; k + 1 < N; k++) begin
            slots[k*IN_WIDTH +: IN_WIDTH] = acc_q[k*IN_WIDTH +: IN_WIDTH];
        end
        slots[(N-1)*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;

        word = '0;
        if (MSB_FIRST) begin
            for (int unsigned k = 0; k < N; k++) begin
                word[OUT_WIDTH-1-k*IN_WIDTH -: IN_WIDTH] = slots[k*IN_WIDTH +: IN_WIDTH];
            end
        end else begin
            word = slots;
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        if (clr) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (accept) begin
            if (complete) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                for (int unsigned k = 0; k + 1 < N; k++) begin
                    if (cnt_q == CntW'(k)) begin
                        acc_d[k*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
                    end
                end
            end
        end

        if (complete) begin
            out_data_d  = word;
            out_valid_d = 1'b1;
        end else if (out_valid_q && m_axis_tready) begin
            out_valid_d = 1'b0;
        end

        partial_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            partial_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            partial_q   <= partial_d;
        end
    end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Scoreboard bench for axis_byte_packer: a 24-bit MSB-first and a 24-bit LSB-first
// instance share one byte stream; a negedge monitor checks every output handshake.
module tb_axis_byte_packer;

    logic        clk;
    logic        arstn;
    logic        clr;
    logic [7:0]  s_tdata;
    logic        s_tvalid;
    logic        m_tready;

    logic        s_tready_m, s_tready_l;
    logic [23:0] m_tdata_m, m_tdata_l;
    logic        m_tvalid_m, m_tvalid_l;
    logic        partial_m, partial_l;

    int tests = 0;
    int fails = 0;

    logic [23:0] exp_m_q[$];
    logic [23:0] exp_l_q[$];

    axis_byte_packer #(.IN_WIDTH(8), .OUT_WIDTH(24), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk           (clk),
        .arstn         (arstn),
        .clr           (clr),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready_m),
        .m_axis_tdata  (m_tdata_m),
        .m_axis_tvalid (m_tvalid_m),
        .m_axis_tready (m_tready),
        .partial       (partial_m)
    );

    axis_byte_packer #(.IN_WIDTH(8), .OUT_WIDTH(24), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk           (clk),
        .arstn         (arstn),
        .clr           (clr),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready_l),
        .m_axis_tdata  (m_tdata_l),
        .m_axis_tvalid (m_tvalid_l),
        .m_axis_tready (m_tready),
        .partial       (partial_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        exp_m_q.push_back({b0, b1, b2});
        exp_l_q.push_back({b2, b1, b0});
    endtask

    // Monitor: every output handshake must match the next expected word.
    always @(negedge clk) begin
        if (arstn && m_tvalid_m && m_tready) begin
            if (exp_m_q.size() == 0) check("msb_unexpected_word", 32'(m_tdata_m), 32'hFFFF_FFFF);
            else check("msb_word", 32'(m_tdata_m), 32'(exp_m_q.pop_front()));
        end
        if (arstn && m_tvalid_l && m_tready) begin
            if (exp_l_q.size() == 0) check("lsb_unexpected_word", 32'(m_tdata_l), 32'hFFFF_FFFF);
            else check("lsb_word", 32'(m_tdata_l), 32'(exp_l_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        arstn    = 1'b0;
        clr      = 1'b0;
        s_tdata  = 8'h00;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        tick();
        tick();
        check("rst_tvalid", 32'(m_tvalid_m), 32'd0);
        check("rst_tdata", 32'(m_tdata_m), 32'd0);
        check("rst_partial", 32'(partial_m), 32'd0);
        check("rst_tready", 32'(s_tready_m), 32'd0);
        arstn = 1'b1;
        #1;
        check("post_rst_tready", 32'(s_tready_m), 32'd1);
        tick();

        // 1/2: basic pack, both byte orders, one-cycle valid after last beat.
        push_word(8'h12, 8'h34, 8'h56);
        s_tvalid = 1'b1;
        s_tdata  = 8'h12;
        tick();
        check("t1_partial_after_first", 32'(partial_m), 32'd1);
        check("t1_tvalid_early", 32'(m_tvalid_m), 32'd0);
        s_tdata = 8'h34;
        tick();
        s_tdata = 8'h56;
        tick();
        s_tvalid = 1'b0;
        check("t1_tvalid_at_t1", 32'(m_tvalid_m), 32'd1);
        check("t1_tdata_msb", 32'(m_tdata_m), 32'h123456);
        check("t1_tdata_lsb", 32'(m_tdata_l), 32'h563412);
        check("t1_partial_done", 32'(partial_m), 32'd0);
        tick();
        check("t1_tvalid_one_cycle", 32'(m_tvalid_m), 32'd0);

        // 3: backpressure holds the word and stalls only the completing beat.
        m_tready = 1'b0;
        push_word(8'h01, 8'h02, 8'h03);
        push_word(8'h04, 8'h05, 8'h06);
        s_tvalid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            s_tdata = 8'(i);
            #1;
            check("t3_tready_accept", 32'(s_tready_m), 32'd1);
            tick();
        end
        s_tdata = 8'h06;
        #1;
        check("t3_tready_stall", 32'(s_tready_m), 32'd0);
        check("t3_tready_stall_lsb", 32'(s_tready_l), 32'd0);
        tick();
        tick();
        check("t3_hold_valid", 32'(m_tvalid_m), 32'd1);
        check("t3_hold_data", 32'(m_tdata_m), 32'h010203);
        check("t3_still_stalled", 32'(s_tready_m), 32'd0);
        m_tready = 1'b1;
        #1;
        check("t3_tready_on_drain", 32'(s_tready_m), 32'd1);
        tick();
        s_tvalid = 1'b0;
        check("t3_no_gap_valid", 32'(m_tvalid_m), 32'd1);
        check("t3_second_word", 32'(m_tdata_m), 32'h040506);
        tick();
        check("t3_drained", 32'(m_tvalid_m), 32'd0);

        // 4: continuous stream, tready never drops, words every third cycle.
        for (int w = 0; w < 3; w++) begin
            push_word(8'hA1 + 8'(3*w), 8'hA2 + 8'(3*w), 8'hA3 + 8'(3*w));
        end
        s_tvalid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            s_tdata = 8'hA1 + 8'(i);
            #1;
            check("t4_tready", 32'(s_tready_m), 32'd1);
            tick();
            check("t4_tvalid_pattern", 32'(m_tvalid_m), (i % 3 == 2) ? 32'd1 : 32'd0);
        end
        s_tvalid = 1'b0;
        tick();

        // 5: clr discards a partial word and beats offered alongside it.
        s_tvalid = 1'b1;
        s_tdata  = 8'hAA;
        tick();
        check("t5_partial_set", 32'(partial_m), 32'd1);
        s_tdata = 8'hBB;
        tick();
        s_tdata = 8'hEE;
        clr     = 1'b1;
        #1;
        check("t5_tready_clr", 32'(s_tready_m), 32'd0);
        tick();
        clr = 1'b0;
        check("t5_partial_cleared", 32'(partial_m), 32'd0);
        push_word(8'h01, 8'h02, 8'h03);
        for (int i = 1; i <= 3; i++) begin
            s_tdata = 8'(i);
            tick();
        end
        s_tvalid = 1'b0;
        check("t5_word_valid", 32'(m_tvalid_m), 32'd1);
        check("t5_word_data", 32'(m_tdata_m), 32'h010203);
        tick();

        // 6: async reset drops a held word and a partial word immediately.
        m_tready = 1'b0;
        s_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_tdata = 8'h11 * 8'(i + 1);
            tick();
        end
        s_tvalid = 1'b0;
        check("t6_held_before_rst", 32'(m_tvalid_m), 32'd1);
        check("t6_partial_before_rst", 32'(partial_m), 32'd1);
        #2;
        arstn = 1'b0;
        #1;
        check("t6_rst_tvalid", 32'(m_tvalid_m), 32'd0);
        check("t6_rst_partial", 32'(partial_m), 32'd0);
        check("t6_rst_tready", 32'(s_tready_m), 32'd0);
        tick();
        arstn    = 1'b1;
        m_tready = 1'b1;
        push_word(8'h77, 8'h88, 8'h99);
        s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_tdata = 8'h77 + 8'(i * 8'h11);
            tick();
        end
        s_tvalid = 1'b0;
        check("t6_word_msb", 32'(m_tdata_m), 32'h778899);
        check("t6_word_lsb", 32'(m_tdata_l), 32'h998877);
        tick();
        tick();

        check("sb_msb_empty", 32'(exp_m_q.size()), 32'd0);
        check("sb_lsb_empty", 32'(exp_l_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
